// File: rtl/branch_resolve_queue_pkg.sv
// Shared types and sizing for the branch resolve queue and its gshare partner.
package branch_resolve_queue_pkg;

  localparam int GSHARE_GHSR_WIDTH = 8;
  localparam int BRQ_DEPTH         = 8;

  typedef struct packed {
    logic [31:0]                  pc;
    logic                         hit;
    logic                         pred_taken;
    logic [31:0]                  pred_target;
    logic [GSHARE_GHSR_WIDTH-1:0] ghsr;
  } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue.sv
// In-order queue of fetched slots with their predictions; retires at EXE,
// drives the predictor update/restore bus and a registered mispredict redirect.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH  = BRQ_DEPTH,
  parameter int GHSR_W = GSHARE_GHSR_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     if_resp,
  input  logic                     if_instr1_valid,
  input  logic [31:0]              if_instr0_pc,
  input  logic [31:0]              if_instr1_pc,
  input  logic                     if_instr0_hit,
  input  logic                     if_instr1_hit,
  input  logic                     if_instr0_pred_taken,
  input  logic                     if_instr1_pred_taken,
  input  logic [31:0]              if_instr0_pred_target,
  input  logic [31:0]              if_instr1_pred_target,
  input  logic [GHSR_W-1:0]        if_instr0_ghsr,
  input  logic [GHSR_W-1:0]        if_instr1_ghsr,
  output logic                     if_stall,
  input  logic                     exe_valid,
  input  logic                     exe_is_bj,
  input  logic                     exe_taken,
  input  logic [31:0]              exe_target,
  input  logic                     pipe_flush,
  output logic                     EXE_is_BJ,
  output logic                     EXE_update_GHSR,
  output logic                     EXE_branch_taken,
  output logic [31:0]              EXE_branch_addr,
  output logic [GHSR_W-1:0]        EXE_GHSR_restore,
  output logic                     redirect_valid,
  output logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     underflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  brq_entry_t        mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr1_idx;
  logic [CW-1:0]     count_q, count_d, free, npush;
  logic              redirect_valid_q, redirect_valid_d;
  logic [31:0]       redirect_pc_q, redirect_pc_d;
  logic              underflow_q, underflow_d;
  logic              push, pop, mispredict, clear, we0, we1;
  brq_entry_t        head, e0, e1;

  assign head = mem_q[rd_ptr_q];
  assign e0 = '{pc: if_instr0_pc, hit: if_instr0_hit, pred_taken: if_instr0_pred_taken,
                pred_target: if_instr0_pred_target, ghsr: GSHARE_GHSR_WIDTH'(if_instr0_ghsr)};
  assign e1 = '{pc: if_instr1_pc, hit: if_instr1_hit, pred_taken: if_instr1_pred_taken,
                pred_target: if_instr1_pred_target, ghsr: GSHARE_GHSR_WIDTH'(if_instr1_ghsr)};

  always_comb begin
    free       = CW'(DEPTH) - count_q;
    if_stall   = free < CW'(2);
    push       = if_resp && !if_stall;
    npush      = push ? (if_instr1_valid ? CW'(2) : CW'(1)) : '0;
    // Flush wins over everything, including the pop it would otherwise retire.
    pop        = exe_valid && (count_q != '0) && !pipe_flush;
    mispredict = pop && exe_is_bj &&
                 (!head.hit || (head.pred_taken != exe_taken) ||
                  (exe_taken && (head.pred_target != exe_target)));
    clear      = pipe_flush || mispredict;
    we0        = push && !clear;
    we1        = we0 && if_instr1_valid;
    wr1_idx    = wr_ptr_q + AW'(1);

    EXE_is_BJ        = pop && exe_is_bj;
    EXE_update_GHSR  = EXE_is_BJ && mispredict;
    EXE_branch_taken = pop && exe_taken;
    EXE_branch_addr  = pop ? head.pc : '0;
    EXE_GHSR_restore = pop ? GHSR_W'(head.ghsr) : '0;

    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    redirect_valid_d = mispredict;
    redirect_pc_d    = redirect_pc_q;
    underflow_d      = underflow_q || (exe_valid && (count_q == '0));

    if (mispredict)
      redirect_pc_d = exe_taken ? exe_target : head.pc + 32'd4;

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + (if_instr1_valid ? AW'(2) : AW'(1));
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + npush - (pop ? CW'(1) : CW'(0));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      underflow_q      <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      underflow_q      <= underflow_d;
    end
  end

  // Payload storage carries no reset; occupancy alone says what is live.
  always_ff @(posedge clk) begin
    if (we0) mem_q[wr_ptr_q] <= e0;
    if (we1) mem_q[wr1_idx]  <= e1;
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign count          = count_q;
  assign underflow_err  = underflow_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed plus random checking of branch_resolve_queue against a queue-based model.
module tb_branch_resolve_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic        hit;
    logic        pt;
    logic [31:0] tgt;
    logic [7:0]  ghsr;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_resp, if_instr1_valid;
  ent_t        s0, s1;
  logic        if_stall;
  logic        exe_valid, exe_is_bj, exe_taken;
  logic [31:0] exe_target;
  logic        pipe_flush;
  logic        EXE_is_BJ, EXE_update_GHSR, EXE_branch_taken;
  logic [31:0] EXE_branch_addr;
  logic [7:0]  EXE_GHSR_restore;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [3:0]  count;
  logic        underflow_err;

  int nvec = 0;
  int nerr = 0;

  ent_t        mq[$];
  bit          m_uf, m_rv;
  logic [31:0] m_rpc;

  always #5 clk = ~clk;

  branch_resolve_queue #(.DEPTH(8), .GHSR_W(8)) dut (
    .clk(clk), .reset(reset),
    .if_resp(if_resp), .if_instr1_valid(if_instr1_valid),
    .if_instr0_pc(s0.pc), .if_instr1_pc(s1.pc),
    .if_instr0_hit(s0.hit), .if_instr1_hit(s1.hit),
    .if_instr0_pred_taken(s0.pt), .if_instr1_pred_taken(s1.pt),
    .if_instr0_pred_target(s0.tgt), .if_instr1_pred_target(s1.tgt),
    .if_instr0_ghsr(s0.ghsr), .if_instr1_ghsr(s1.ghsr),
    .if_stall(if_stall),
    .exe_valid(exe_valid), .exe_is_bj(exe_is_bj), .exe_taken(exe_taken),
    .exe_target(exe_target), .pipe_flush(pipe_flush),
    .EXE_is_BJ(EXE_is_BJ), .EXE_update_GHSR(EXE_update_GHSR),
    .EXE_branch_taken(EXE_branch_taken), .EXE_branch_addr(EXE_branch_addr),
    .EXE_GHSR_restore(EXE_GHSR_restore),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .count(count), .underflow_err(underflow_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    if_resp = 0; if_instr1_valid = 0; s0 = '0; s1 = '0;
    exe_valid = 0; exe_is_bj = 0; exe_taken = 0; exe_target = '0; pipe_flush = 0;
  endtask

  function automatic ent_t mk(input logic [31:0] pc, input logic hit, input logic pt,
                              input logic [31:0] tgt, input logic [7:0] g);
    ent_t e;
    e.pc = pc; e.hit = hit; e.pt = pt; e.tgt = tgt; e.ghsr = g;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    return mk($urandom & 32'hFFFF_FFFC, ($urandom % 10) != 0, 1'($urandom),
              $urandom & 32'hFFFF_FFFC, 8'($urandom));
  endfunction

  task automatic model_reset();
    mq.delete(); m_uf = 0; m_rv = 0; m_rpc = '0;
  endtask

  // One clock: check the same-cycle update bus, clock, advance model, check registered state.
  task automatic step();
    ent_t h;
    bit   stall, dpush, pop, mis, uf_now;
    int   sz;
    #1;
    sz     = mq.size();
    stall  = (8 - sz) < 2;
    dpush  = if_resp && !stall;
    pop    = exe_valid && sz > 0 && !pipe_flush;
    uf_now = exe_valid && sz == 0;
    h      = (sz > 0) ? mq[0] : '0;
    mis    = pop && exe_is_bj &&
             (!h.hit || h.pt != exe_taken || (exe_taken && h.tgt != exe_target));
    chk("if_stall", 32'(if_stall), 32'(stall));
    chk("is_bj", 32'(EXE_is_BJ), 32'(pop && exe_is_bj));
    chk("upd_ghsr", 32'(EXE_update_GHSR), 32'(mis));
    chk("br_taken", 32'(EXE_branch_taken), 32'(pop && exe_taken));
    if (pop) begin
      chk("br_addr", EXE_branch_addr, h.pc);
      chk("ghsr_rst", 32'(EXE_GHSR_restore), 32'(h.ghsr));
    end
    @(posedge clk); #1;
    if (uf_now) m_uf = 1;
    m_rv = mis;
    if (mis) m_rpc = exe_taken ? exe_target : h.pc + 32'd4;
    if (pipe_flush || mis) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (dpush) begin
        mq.push_back(s0);
        if (if_instr1_valid) mq.push_back(s1);
      end
    end
    chk("count", 32'(count), mq.size());
    chk("redir_v", 32'(redirect_valid), 32'(m_rv));
    chk("redir_pc", redirect_pc, m_rpc);
    chk("underflow", 32'(underflow_err), 32'(m_uf));
  endtask

  task automatic push1(input ent_t a);
    idle(); if_resp = 1; s0 = a; step();
  endtask

  task automatic push2(input ent_t a, input ent_t b);
    idle(); if_resp = 1; if_instr1_valid = 1; s0 = a; s1 = b; step();
  endtask

  task automatic pop_nb();
    idle(); exe_valid = 1; step();
  endtask

  initial begin
    idle();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_count", 32'(count), 0);
    chk("rst_stall", 32'(if_stall), 0);
    chk("rst_rv", 32'(redirect_valid), 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_uf", 32'(underflow_err), 0);

    // Correctly predicted taken branch
    push1(mk(32'h100, 1, 1, 32'h200, 8'h3A));
    chk("cp_cnt1", 32'(count), 1);
    idle(); exe_valid = 1; exe_is_bj = 1; exe_taken = 1; exe_target = 32'h200;
    #1;
    chk("cp_isbj", 32'(EXE_is_BJ), 1);
    chk("cp_upd", 32'(EXE_update_GHSR), 0);
    chk("cp_addr", EXE_branch_addr, 32'h100);
    step();
    chk("cp_cnt0", 32'(count), 0);
    chk("cp_norv", 32'(redirect_valid), 0);

    // Direction mispredict
    push1(mk(32'h40, 1, 1, 32'h80, 8'h05));
    idle(); exe_valid = 1; exe_is_bj = 1; exe_taken = 0; exe_target = 32'h80;
    #1;
    chk("dm_upd", 32'(EXE_update_GHSR), 1);
    chk("dm_ghsr", 32'(EXE_GHSR_restore), 32'h05);
    step();
    chk("dm_rv", 32'(redirect_valid), 1);
    chk("dm_rpc", redirect_pc, 32'h44);
    chk("dm_cnt", 32'(count), 0);
    idle(); step();
    chk("dm_pulse", 32'(redirect_valid), 0);

    // BTB miss resolved not-taken still resyncs
    push1(mk(32'h80, 0, 0, 32'h0, 8'h11));
    idle(); exe_valid = 1; exe_is_bj = 1; exe_taken = 0; step();
    chk("btb_rv", 32'(redirect_valid), 1);
    chk("btb_rpc", redirect_pc, 32'h84);

    // Fill to 7, stalled push ignored, then wrap the two-slot write across 7->0
    push2(mk(32'h1000, 1, 0, 0, 1), mk(32'h1004, 1, 0, 0, 2));
    push2(mk(32'h1008, 1, 0, 0, 3), mk(32'h100C, 1, 0, 0, 4));
    push2(mk(32'h1010, 1, 0, 0, 5), mk(32'h1014, 1, 0, 0, 6));
    chk("full_nostall6", 32'(if_stall), 0);
    push1(mk(32'h1018, 1, 0, 0, 7));
    chk("full_cnt7", 32'(count), 7);
    chk("full_stall", 32'(if_stall), 1);
    push2(mk(32'hDEAD, 1, 0, 0, 8), mk(32'hBEEF, 1, 0, 0, 9));
    chk("full_ignored", 32'(count), 7);
    repeat (3) pop_nb();
    push2(mk(32'h101C, 1, 0, 0, 10), mk(32'h1020, 1, 0, 0, 11));
    chk("wrap_cnt", 32'(count), 6);
    for (int i = 0; i < 6; i++) begin
      idle(); exe_valid = 1;
      #1 chk("wrap_order", EXE_branch_addr, 32'h100C + 32'(4 * i));
      step();
    end

    // Flush alongside a mispredicting pop: flush wins
    push1(mk(32'h300, 1, 1, 32'h400, 8'h22));
    idle(); exe_valid = 1; exe_is_bj = 1; exe_taken = 0; pipe_flush = 1;
    if_resp = 1; s0 = mk(32'h500, 1, 0, 0, 0);
    #1;
    chk("fl_isbj", 32'(EXE_is_BJ), 0);
    chk("fl_upd", 32'(EXE_update_GHSR), 0);
    step();
    chk("fl_cnt", 32'(count), 0);
    chk("fl_norv", 32'(redirect_valid), 0);

    // Underflow is sticky
    pop_nb();
    chk("uf_set", 32'(underflow_err), 1);
    idle(); step(); step();
    chk("uf_sticky", 32'(underflow_err), 1);

    // Asynchronous reset with count = 5
    push2(rnd_ent(), rnd_ent());
    push2(rnd_ent(), rnd_ent());
    push1(rnd_ent());
    chk("ar_cnt5", 32'(count), 5);
    idle();
    #2 reset = 1;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_stall", 32'(if_stall), 0);
    chk("ar_rv", 32'(redirect_valid), 0);
    chk("ar_uf", 32'(underflow_err), 0);
    model_reset();
    @(posedge clk); #1 reset = 0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      if_resp = 1'($urandom);
      if_instr1_valid = 1'($urandom);
      s0 = rnd_ent();
      s1 = rnd_ent();
      exe_valid = ($urandom % 3) != 0;
      exe_is_bj = 1'($urandom);
      if (mq.size() > 0 && ($urandom % 4) != 0) begin
        exe_taken  = mq[0].pt;
        exe_target = mq[0].tgt;
      end else begin
        exe_taken  = 1'($urandom);
        exe_target = $urandom & 32'hFFFF_FFFC;
      end
      pipe_flush = ($urandom % 30) == 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
